// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_SRC stream sources, the round-robin arbiter and the FIFO write port.
// master = sources plus FIFO side (testbench / surrounding logic), slave = the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64
);
  localparam int ID_WIDTH = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]            s_valid;
  logic [NUM_SRC-1:0]            s_last;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_data;
  logic [NUM_SRC-1:0]            s_ready;
  logic                          fifo_full;
  logic                          fifo_wen;
  logic [ID_WIDTH+DATA_WIDTH:0]  fifo_wdata;

  modport master (
    output s_valid, s_last, s_data, fifo_full,
    input  s_ready, fifo_wen, fifo_wdata
  );

  modport slave (
    input  s_valid, s_last, s_data, fifo_full,
    output s_ready, fifo_wen, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler sharing one async FIFO write port among NUM_SRC sources; beats packed as {src_id, last, data}.
// Optional per-grant burst limit enabled by defining FIFO_WR_ARB_BURST_LIMIT_EN.
module fifo_wr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
  parameter int MAX_BURST  = 16,
`endif
  localparam int ID_WIDTH  = $clog2(NUM_SRC)
) (
  input  logic                 wclk,
  input  logic                 wresetn,
  fifo_wr_arbiter_if.slave     bus,
  output logic                 busy,
  output logic [ID_WIDTH-1:0]  grant_id
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                       state_reg, state_next;
  logic [ID_WIDTH-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [ID_WIDTH-1:0]          grant_reg, grant_next;
  logic                         wen_reg, wen_next;
  logic [ID_WIDTH+DATA_WIDTH:0] wdata_reg, wdata_next;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [ID_WIDTH-1:0]   cand_idx [NUM_SRC];
  logic [ID_WIDTH-1:0]   pick;
  logic                  pick_ok;
  logic                  hs;
  logic                  g_last;
  logic [ID_WIDTH-1:0]   grant_inc;

`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
  localparam int CNT_WIDTH = $clog2(MAX_BURST) + 1;
  logic [CNT_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;
`endif

  // cand_idx[k] is the source at priority k: rr_ptr + k, wrapped for non-power-of-two NUM_SRC
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [ID_WIDTH:0] sum;
      assign src_data[gi] = bus.s_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sum          = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(gi);
      assign cand_idx[gi] = (sum >= (ID_WIDTH+1)'(NUM_SRC))
                            ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_SRC))
                            : sum[ID_WIDTH-1:0];
    end
  endgenerate

  // Scan from lowest priority upward so the highest-priority requester wins last
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (bus.s_valid[cand_idx[k]]) begin
        pick    = cand_idx[k];
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    bus.s_ready = '0;
    if (state_reg == XFER && !bus.fifo_full) begin
      bus.s_ready[grant_reg] = 1'b1;
    end
  end

  assign hs        = (state_reg == XFER) && bus.s_valid[grant_reg] && !bus.fifo_full;
  assign g_last    = bus.s_last[grant_reg];
  assign grant_inc = (grant_reg == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    wen_next    = hs;
    wdata_next  = wdata_reg;
`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
    beat_cnt_next = beat_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_ok) begin
          grant_next = pick;
          state_next = XFER;
        end
      end
      XFER: begin
        if (hs) begin
          wdata_next = {grant_reg, g_last, src_data[grant_reg]};
`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
          if (g_last || beat_cnt_reg == CNT_WIDTH'(MAX_BURST - 1)) begin
            state_next    = IDLE;
            rr_ptr_next   = grant_inc;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
`else
          if (g_last) begin
            state_next  = IDLE;
            rr_ptr_next = grant_inc;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wresetn) begin
    if (!wresetn) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      wen_reg    <= 1'b0;
      wdata_reg  <= '0;
`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
      beat_cnt_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      wen_reg    <= wen_next;
      wdata_reg  <= wdata_next;
`ifdef FIFO_WR_ARB_BURST_LIMIT_EN
      beat_cnt_reg <= beat_cnt_next;
`endif
    end
  end

  assign busy           = (state_reg == XFER);
  assign grant_id       = grant_reg;
  assign bus.fifo_wen   = wen_reg;
  assign bus.fifo_wdata = wdata_reg;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side scheduler that lets NUM_SRC stream sources share the write port of one async_fifo instance.
- Sits entirely in the wclk domain.
- Packs each granted beat as {src_id, last, data}, drives the FIFO write port, and back-pressures sources from the FIFO full indication.
- Read-side consumers use src_id and last to de-multiplex packets.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- DATA_WIDTH, 64, payload bits per beat.
- ID_WIDTH, $clog2(NUM_SRC), source-id field width (localparam).
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (optional feature only).

Ports:
- wclk  in  1  write-domain clock.
- wresetn  in  1  asynchronous active-low reset, wclk domain.
- s_valid  in  NUM_SRC  per-source beat valid.
- s_last  in  NUM_SRC  per-source end-of-packet flag.
- s_data  in  NUM_SRC*DATA_WIDTH  flattened payload; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_ready  out  NUM_SRC  per-source beat accepted.
- fifo_full  in  1  FIFO full; a conservative flag asserted with at least 2 entries of margin.
- fifo_wen  out  1  FIFO write enable.
- fifo_wdata  out  ID_WIDTH+1+DATA_WIDTH  {src_id, last, data}.
- busy  out  1  a grant is held.
- grant_id  out  ID_WIDTH  currently granted source.

Behaviour:
- Reset, async on wresetn low: state=IDLE, rr_ptr=0, grant_id=0, busy=0, fifo_wen=0, fifo_wdata=0, s_ready=0.
- State machine, two states:
  - IDLE: if any s_valid, select the first asserted source starting at rr_ptr, wrapping modulo NUM_SRC. Latch grant_id and go to XFER the next cycle; busy=1. No beat is transferred in the arbitration cycle.
  - XFER: s_ready[grant_id] = ~fifo_full. All other s_ready bits are 0.
- Beat handshake: s_valid[g] & s_ready[g].
- Beat capture: on a handshake, the next cycle presents fifo_wen=1 and fifo_wdata={grant_id, s_last[g], s_data[g]}. Output stage is registered; latency source handshake -> fifo_wen is 1 cycle.
- Idle output: fifo_wen=0 in any cycle without a prior-cycle handshake. fifo_wdata holds its last value.
- End of packet: a handshake with s_last[g]=1 returns to IDLE and sets rr_ptr=(g+1) mod NUM_SRC.
- Back-to-back packets: consecutive packets cost one idle arbitration cycle each.
- Source stall: if s_valid[g] drops mid-packet, the grant is held (no timeout), with no FIFO write that cycle.
- fifo_full high: s_ready=0 and no new beats. The beat already in the output register is still written; the 2-entry margin covers it.
- Packet ordering: beats of one packet are never interleaved with another source while the optional feature is off.
- Mid-operation reset: returns immediately to the reset state. A partially forwarded packet is truncated with no trailing last beat; the read side discards it after its own reset.
- rr_ptr arithmetic: wraps NUM_SRC-1 -> 0. Non-power-of-two NUM_SRC is supported.

Optional Feature:
- Macro: FIFO_WR_ARB_BURST_LIMIT_EN.
- Enabled:
  - A beat counter (width $clog2(MAX_BURST)+1) counts handshakes within the current grant.
  - When it reaches MAX_BURST without s_last, the arbiter returns to IDLE, advances rr_ptr past g, and resets the counter.
  - The packet resumes on a later grant. The read side reassembles by src_id, since packets may interleave.
  - The counter clears on s_last and on reset.
- Disabled: no counter; the grant is held strictly until s_last.

Test Plan:
- Single source: src1 sends a 3-beat packet (data 0xA,0xB,0xC, last on 3rd), fifo_full=0.
  - Expect one arbitration cycle, then s_ready[1]=1 for 3 cycles.
  - Expect fifo_wen pulses one cycle later with fifo_wdata={1,0,0xA},{1,0,0xB},{1,1,0xC}.
  - Expect busy=0 afterwards and rr_ptr=2.
- Round-robin fairness: all 4 sources continuously send 1-beat packets from reset.
  - Expect grant order 0,1,2,3,0.
  - Expect one FIFO write every 2 cycles.
- Back-pressure: fifo_full=1 for 5 cycles in the middle of a 6-beat packet from src2.
  - Expect s_ready=0 and no fifo_wen beyond the already-registered beat.
  - Expect all 6 beats written in order, with no loss or duplication.
- Source stall: src0 deasserts s_valid for 4 cycles mid-packet while src3 is requesting.
  - Expect grant_id to stay 0 and src3 to get no grant until src0's last beat.
- Reset mid-packet: assert wresetn low during beat 2 of 4.
  - Expect fifo_wen=0, s_ready=0, busy=0 immediately.
  - After release, src0 is granted first if requesting.
- FIFO_WR_ARB_BURST_LIMIT_EN with MAX_BURST=4: src0 sends a 10-beat packet while src1 is requesting.
  - Expect src0 beats 1-4, then src1's packet, then src0 beats 5-8, and so on.
  - Expect the last flag only on beat 10.
